// File: rtl/mmio_id_tracker.sv
// ID tracking shim between the ID-carrying MMIO port and the ID-less in-order kernel slave.
// Optional orphan-response detection is compiled in with MMIO_ID_CHECK_EN.
module mmio_id_fifo #(
    parameter int ID_W  = 9,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  logic            pop,
    output logic [ID_W-1:0] head,
    output logic            full,
    output logic            empty
);
    localparam int PW = $clog2(DEPTH);

    logic [ID_W-1:0] mem [DEPTH];
    logic [PW:0]     wr_ptr;
    logic [PW:0]     rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    // Empty FIFO reports ID 0 so orphan responses carry a defined ID
    assign head  = empty ? '0 : mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[PW-1:0]] <= push_id;
    end
endmodule

module mmio_id_tracker #(
    parameter int ID_W   = 9,
    parameter int ADDR_W = 18,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                s_arvalid,
    output logic                s_arready,
    input  logic [ID_W-1:0]     s_arid,
    input  logic [ADDR_W-1:0]   s_araddr,
    output logic                s_rvalid,
    input  logic                s_rready,
    output logic [ID_W-1:0]     s_rid,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [ID_W-1:0]     s_awid,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic                s_wvalid,
    output logic                s_wready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_bvalid,
    input  logic                s_bready,
    output logic [ID_W-1:0]     s_bid,
    output logic [1:0]          s_bresp,
    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [31:0]         m_araddr,
    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [31:0]         m_awaddr,
    output logic                m_wvalid,
    input  logic                m_wready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_bvalid,
    output logic                m_bready,
    input  logic [1:0]          m_bresp,
    output logic                err_orphan
);
    logic            rd_full, rd_empty;
    logic            wr_full, wr_empty;
    logic [ID_W-1:0] rd_head, wr_head;

    mmio_id_fifo #(.ID_W(ID_W), .DEPTH(DEPTH)) u_rd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (s_arvalid && s_arready),
        .push_id (s_arid),
        .pop     (s_rvalid && s_rready),
        .head    (rd_head),
        .full    (rd_full),
        .empty   (rd_empty)
    );

    mmio_id_fifo #(.ID_W(ID_W), .DEPTH(DEPTH)) u_wr_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (s_awvalid && s_awready),
        .push_id (s_awid),
        .pop     (s_bvalid && s_bready),
        .head    (wr_head),
        .full    (wr_full),
        .empty   (wr_empty)
    );

    // Handshakes are gated by reset_n so nothing leaks while held in reset
    assign m_arvalid = reset_n && s_arvalid && !rd_full;
    assign s_arready = reset_n && m_arready && !rd_full;
    assign m_araddr  = 32'(s_araddr);

    assign s_rvalid  = reset_n && m_rvalid;
    assign m_rready  = reset_n && s_rready;
    assign s_rid     = rd_head;
    assign s_rdata   = m_rdata;
    assign s_rresp   = m_rresp;

    assign m_awvalid = reset_n && s_awvalid && !wr_full;
    assign s_awready = reset_n && m_awready && !wr_full;
    assign m_awaddr  = 32'(s_awaddr);

    assign m_wvalid  = reset_n && s_wvalid;
    assign s_wready  = reset_n && m_wready;
    assign m_wdata   = s_wdata;
    assign m_wstrb   = s_wstrb;

    assign s_bvalid  = reset_n && m_bvalid;
    assign m_bready  = reset_n && s_bready;
    assign s_bid     = wr_head;
    assign s_bresp   = m_bresp;

`ifdef MMIO_ID_CHECK_EN
    logic err_q;
    logic orphan;

    assign orphan     = (m_rvalid && rd_empty) || (m_bvalid && wr_empty);
    assign err_orphan = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_q <= 1'b0;
        else if (orphan)
            err_q <= 1'b1;
    end
`else
    assign err_orphan = 1'b0;
`endif
endmodule

// File: tb/tb_mmio_id_tracker.sv
// Scoreboard bench for mmio_id_tracker: random MMIO master, in-order kernel model, monitor.
module tb_mmio_id_tracker;
    localparam int ID_W   = 9;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 4;
`ifdef MMIO_ID_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic s_arvalid, s_arready, s_rvalid, s_rready;
    logic [ID_W-1:0] s_arid, s_rid, s_awid, s_bid;
    logic [ADDR_W-1:0] s_araddr, s_awaddr;
    logic [DATA_W-1:0] s_rdata, s_wdata, m_rdata, m_wdata;
    logic [1:0] s_rresp, s_bresp, m_rresp, m_bresp;
    logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [DATA_W/8-1:0] s_wstrb, m_wstrb;
    logic m_arvalid, m_arready, m_rvalid, m_rready;
    logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [31:0] m_araddr, m_awaddr;
    logic err_orphan;

    mmio_id_tracker #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
        .s_rresp(s_rresp),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .err_orphan(err_orphan)
    );

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } rsp_t;

    int n_cmp = 0;
    int n_bad = 0;
    rsp_t exp_r[$];
    logic [ID_W-1:0] exp_b[$];
    logic [ID_W-1:0] dir_rid[$];
    logic [ID_W-1:0] dir_wid[$];
    logic [ADDR_W-1:0] dir_raddr[$];
    logic [31:0] k_raddr[$];
    int k_aw, k_w, k_b;
    int rd_out, wr_out, aw_iss, w_iss;
    int max_out = 1000;
    bit traffic_en, kresp_en, orphan_b;
    bit ar_done, aw_done, w_done, r_done, b_done, b_orph_done;

    function automatic logic [DATA_W-1:0] rdata_of(input logic [31:0] a);
        return {a ^ 32'hA5C3_0F69, ~a + 32'd17};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Upstream MMIO master
    initial begin
        s_arvalid = 0; s_arid = 0; s_araddr = 0; s_rready = 0;
        s_awvalid = 0; s_awid = 0; s_awaddr = 0;
        s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_bready = 0;
        forever begin
            @(posedge clk); #1;
            if (!reset_n) begin
                s_arvalid = 0; s_awvalid = 0; s_wvalid = 0;
                s_rready = 0; s_bready = 0;
                aw_iss = 0; w_iss = 0;
                ar_done = 0; aw_done = 0; w_done = 0;
            end else begin
                if (ar_done) s_arvalid = 0;
                if (aw_done) s_awvalid = 0;
                if (w_done) s_wvalid = 0;
                ar_done = 0; aw_done = 0; w_done = 0;
                if (!s_arvalid && traffic_en && rd_out < max_out && $urandom_range(0, 3) != 0) begin
                    s_arvalid = 1;
                    s_arid = (dir_rid.size() != 0) ? dir_rid.pop_front() : ID_W'($urandom);
                    s_araddr = (dir_raddr.size() != 0) ? dir_raddr.pop_front() : ADDR_W'($urandom);
                end
                if (!s_awvalid && traffic_en && $urandom_range(0, 3) != 0) begin
                    s_awvalid = 1;
                    s_awid = (dir_wid.size() != 0) ? dir_wid.pop_front() : ID_W'($urandom);
                    s_awaddr = ADDR_W'($urandom);
                    aw_iss++;
                end
                if (!s_wvalid && w_iss < aw_iss && $urandom_range(0, 2) != 0) begin
                    s_wvalid = 1;
                    s_wdata = {$urandom, $urandom};
                    s_wstrb = (s_awid == 9'h055) ? 8'hFF : 8'($urandom);
                    w_iss++;
                end
                s_rready = $urandom_range(0, 3) != 0;
                s_bready = $urandom_range(0, 3) != 0;
            end
            @(negedge clk);
            if (reset_n) begin
                check("s_arready", s_arready, m_arready && rd_out < DEPTH);
                check("m_arvalid", m_arvalid, s_arvalid && rd_out < DEPTH);
                check("s_awready", s_awready, m_awready && wr_out < DEPTH);
                if (s_arvalid && s_arready) begin
                    exp_r.push_back('{id: s_arid, data: rdata_of({14'd0, s_araddr})});
                    rd_out++;
                    ar_done = 1;
                end
                if (s_rvalid && s_rready && rd_out > 0) rd_out--;
                if (s_awvalid && s_awready) begin
                    exp_b.push_back(s_awid);
                    wr_out++;
                    aw_done = 1;
                end
                if (s_bvalid && s_bready && wr_out > 0) wr_out--;
                if (s_wvalid && s_wready) begin
                    check("m_wdata", m_wdata, s_wdata);
                    check("m_wstrb", m_wstrb, s_wstrb);
                    w_done = 1;
                end
            end
        end
    end

    // Downstream in-order kernel model
    initial begin
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
        forever begin
            @(posedge clk); #1;
            if (!reset_n) begin
                m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
                k_raddr.delete();
                k_aw = 0; k_w = 0; k_b = 0;
                r_done = 0; b_done = 0; b_orph_done = 0;
            end else begin
                if (r_done) m_rvalid = 0;
                if (b_done) m_bvalid = 0;
                if (b_orph_done) orphan_b = 0;
                r_done = 0; b_done = 0; b_orph_done = 0;
                m_arready = $urandom_range(0, 4) != 0;
                m_awready = $urandom_range(0, 4) != 0;
                m_wready = $urandom_range(0, 4) != 0;
                if (!m_rvalid && kresp_en && k_raddr.size() != 0 && $urandom_range(0, 2) != 0) begin
                    m_rvalid = 1;
                    m_rdata = rdata_of(k_raddr[0]);
                end
                if (!m_bvalid && (orphan_b || (kresp_en && k_b < k_aw && k_b < k_w))
                    && $urandom_range(0, 2) != 0)
                    m_bvalid = 1;
            end
            @(negedge clk);
            if (m_arvalid && m_arready) begin
                check("m_araddr", m_araddr, {14'd0, s_araddr});
                k_raddr.push_back(m_araddr);
            end
            if (m_rvalid && m_rready) begin
                if (k_raddr.size() != 0) k_raddr.delete(0);
                r_done = 1;
            end
            if (m_awvalid && m_awready) k_aw++;
            if (m_wvalid && m_wready) k_w++;
            if (m_bvalid && m_bready) begin
                if (orphan_b) b_orph_done = 1;
                else k_b++;
                b_done = 1;
            end
        end
    end

    // Response monitor
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (s_rvalid && s_rready) begin
                if (exp_r.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL r_unexpected: got id %h, expected no response", s_rid);
                end else begin
                    e = exp_r.pop_front();
                    check("s_rid", s_rid, e.id);
                    check("s_rdata", s_rdata, e.data);
                end
            end
            if (s_bvalid && s_bready) begin
                if (exp_b.size() == 0) begin
                    if (orphan_b) check("orphan_bid", s_bid, 0);
                    else begin
                        n_cmp++; n_bad++;
                        $display("FAIL b_unexpected: got id %h, expected no response", s_bid);
                    end
                end else begin
                    check("s_bid", s_bid, exp_b.pop_front());
                    check("s_bresp", s_bresp, m_bresp);
                end
            end
        end
    end

    task automatic chk_idle(input string tag);
        check({tag, "_out_valids"},
              {m_arvalid, s_rvalid, m_awvalid, m_wvalid, s_bvalid}, 0);
        check({tag, "_out_readys"},
              {s_arready, m_rready, s_awready, s_wready, m_bready}, 0);
        check({tag, "_ids"}, {s_rid, s_bid}, 0);
        check({tag, "_err"}, err_orphan, 0);
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (!(exp_r.size() == 0 && exp_b.size() == 0 && !s_arvalid &&
                 !s_awvalid && !s_wvalid) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 4000) fail(tag);
    endtask

    initial begin
        int t;
        traffic_en = 0; kresp_en = 0; orphan_b = 0;
        rd_out = 0; wr_out = 0;
        #2;
        chk_idle("reset");
        repeat (3) @(negedge clk);
        reset_n = 1;

        // single read, zero-extended address
        dir_rid.push_back(9'h1A5);
        dir_raddr.push_back(18'h00040);
        kresp_en = 1;
        traffic_en = 1;
        repeat (40) @(negedge clk);
        traffic_en = 0;
        drain("drain_single");

        // fill read FIFO with responses held, 5th read must stall
        kresp_en = 0;
        for (int i = 1; i <= 5; i++) dir_rid.push_back(ID_W'(i));
        max_out = 5;
        traffic_en = 1;
        t = 0;
        while (!(rd_out == DEPTH && s_arvalid && dir_rid.size() == 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) fail("fill_rd_fifo");
        traffic_en = 0;
        repeat (4) @(negedge clk);
        check("stall_arready", s_arready, 0);
        check("stall_m_arvalid", m_arvalid, 0);
        kresp_en = 1;
        drain("drain_stall");
        max_out = 1000;

        // random traffic with bursty kernel responses
        traffic_en = 1;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (i % 16 == 0) kresp_en = $urandom_range(0, 9) < 7;
        end
        traffic_en = 0;
        kresp_en = 1;
        drain("drain_random");

        // orphan write response
        @(posedge clk); #2;
        orphan_b = 1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!m_bvalid && t < 20);
        if (!m_bvalid) fail("orphan_bvalid");
        check("orphan_s_bvalid", s_bvalid, 1);
        check("orphan_s_bid", s_bid, 0);
        check("orphan_err_first", err_orphan, 0);
        @(negedge clk);
        check("orphan_err_next", err_orphan, EXP_ERR);
        t = 0;
        while (orphan_b && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (orphan_b) fail("orphan_done");

        // directed write with interleaved reads after the orphan
        dir_wid.push_back(9'h055);
        traffic_en = 1;
        repeat (30) @(negedge clk);
        traffic_en = 0;
        drain("drain_write");
        check("orphan_err_sticky", err_orphan, EXP_ERR);

        // reset with three reads outstanding
        kresp_en = 0;
        max_out = 3;
        traffic_en = 1;
        t = 0;
        while (rd_out != 3 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) fail("three_outstanding");
        @(posedge clk); #2;
        reset_n = 0;
        #1;
        chk_idle("mid_reset");
        traffic_en = 0;
        exp_r.delete();
        exp_b.delete();
        rd_out = 0;
        wr_out = 0;
        repeat (3) @(negedge clk);
        dir_rid.push_back(ID_W'(7));
        max_out = 1000;
        kresp_en = 1;
        reset_n = 1;
        traffic_en = 1;
        repeat (20) @(negedge clk);
        traffic_en = 0;
        drain("drain_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
